// File: rtl/piano_timing_pkg.sv
// Shared timing constants for the piano clock tree: system clock rate,
// the reset divisor (1 s tick at 100 MHz) and tone divisors for square-wave
// note generators (square period = 2*div cycles, so div = CLK_HZ / (2*f)).
package piano_timing_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEFAULT_DIV = 100_000_000;

    // Divisor for a 50% square wave at freq_hz; 0 Hz maps to 0 (never written,
    // because a zero divisor write is dropped by the channel).
    function automatic int unsigned note_div(input int unsigned freq_hz);
        if (freq_hz == 0) begin
            return 0;
        end
        return CLK_HZ / (2 * freq_hz);
    endfunction

    localparam int unsigned DIV_A3 = CLK_HZ / (2 * 220);   // 227272
    localparam int unsigned DIV_A4 = CLK_HZ / (2 * 440);   // 113636
    localparam int unsigned DIV_A5 = CLK_HZ / (2 * 880);   // 56818

endpackage

// File: rtl/prog_clock_divider_div_channel.sv
// One divider channel: counter, active divisor, pending divisor, tick and square outputs.
// Latency: tick/sq registered, first tick div cycles after leaving cnt=0.
// Backpressure: none; divisor writes are accepted every cycle (last write wins).
// Ports: clk, reset (async, active-high), i_en run enable, i_clr phase clear,
//        i_wr/i_wr_val divisor write, o_tick one-cycle pulse, o_sq square, o_pend reload pending.
module div_channel #(
    parameter int                CNT_W       = 32,
    parameter logic [CNT_W-1:0]  DEFAULT_DIV = CNT_W'(piano_timing_pkg::DEFAULT_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_val,
    output logic             o_tick,
    output logic             o_sq,
    output logic             o_pend
);
    import piano_timing_pkg::*;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_val;
    logic             r_pend;
    logic             r_tick;
    logic             r_sq;

    logic [CNT_W-1:0] w_last;
    logic             w_tc;
    logic             w_wr_ok;

    // r_div is never 0, so r_div-1 cannot underflow.
    assign w_last  = r_div - ONE;
    assign w_tc    = (r_cnt == w_last);
    assign w_wr_ok = i_wr && (i_wr_val != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_div      <= DEFAULT_DIV;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_tick     <= 1'b0;
            r_sq       <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_pend_val <= i_wr_val;
            end

            if (i_clr || !i_en) begin
                // Idle/cleared: no period in progress, so any pending divisor
                // can be applied right away. A write this cycle stays pending
                // and is applied on the following edge.
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_sq   <= 1'b0;
                if (r_pend) begin
                    r_div <= r_pend_val;
                end
                r_pend <= w_wr_ok;
            end else if (w_tc) begin
                // Period boundary: the only point a running channel swaps
                // divisors, so a period never mixes two divisors and the
                // counter can never be left above the new div-1.
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_sq   <= ~r_sq;
                if (w_wr_ok) begin
                    r_div <= i_wr_val;
                end else if (r_pend) begin
                    r_div <= r_pend_val;
                end
                r_pend <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + ONE;
                r_tick <= 1'b0;
                if (w_wr_ok) begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;
    assign o_pend = r_pend;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable divider: per-channel tick enable and 50% square wave, all in clk.
// Latency: outputs registered; divisor write lands in pend next edge, applied at terminal count.
// Backpressure: none; div_wr is a single-cycle strobe, writes to div_sel >= N_CH are dropped.
// Ports: clk, reset (async, active-high), en[N_CH], clr, div_wr/div_sel/div_val,
//        tick[N_CH], sq[N_CH], pend[N_CH].
module prog_clock_divider #(
    parameter int               N_CH        = 4,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(piano_timing_pkg::DEFAULT_DIV),
    parameter int               SEL_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             clr,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq,
    output logic [N_CH-1:0]  pend
);
    import piano_timing_pkg::*;

    logic [N_CH-1:0] w_wr;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            // Out-of-range selects match no channel and are silently dropped.
            assign w_wr[g] = div_wr && (div_sel == SEL_W'(g));

            div_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .i_en     (en[g]),
                .i_clr    (clr),
                .i_wr     (w_wr[g]),
                .i_wr_val (div_val),
                .o_tick   (tick[g]),
                .o_sq     (sq[g]),
                .o_pend   (pend[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

    logic        clk;
    logic        reset;
    logic [3:0]  en;
    logic        clr;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [31:0] div_val;
    logic [3:0]  tick, sq, pend;
    logic [2:0]  tick3, sq3, pend3;
    logic [2:0]  en3;

    assign en3 = en[2:0];

    int n_cmp = 0;
    int n_bad = 0;

    prog_clock_divider #(.N_CH(4), .CNT_W(32), .DEFAULT_DIV(32'd10), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .div_wr(div_wr),
        .div_sel(div_sel), .div_val(div_val), .tick(tick), .sq(sq), .pend(pend)
    );

    // Three-channel copy sharing the write bus: div_sel=3 must be dropped here.
    prog_clock_divider #(.N_CH(3), .CNT_W(32), .DEFAULT_DIV(32'd10), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .en(en3), .clr(clr), .div_wr(div_wr),
        .div_sel(div_sel), .div_val(div_val), .tick(tick3), .sq(sq3), .pend(pend3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  en;
        logic        clr;
        logic        wr;
        logic [1:0]  sel;
        logic [31:0] val;
        logic [3:0]  exp_tick;
        logic [3:0]  exp_sq;
        logic [3:0]  exp_pend;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] e, input logic c, input logic w, input logic [1:0] s,
                       input logic [31:0] v, input logic [3:0] t, input logic [3:0] q,
                       input logic [3:0] p);
        vec_t r;
        r.en = e; r.clr = c; r.wr = w; r.sel = s; r.val = v;
        r.exp_tick = t; r.exp_sq = q; r.exp_pend = p;
        vq.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] e, input logic c, input logic w,
                         input logic [1:0] s, input logic [31:0] v);
        en = e; clr = c; div_wr = w; div_sel = s; div_val = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 2'd0, 32'd0);

        // ---- vector table: start-up, mid-period reload, write at terminal count ----
        // Start-up, ch0 div=10: edge k after enable gives tick at k%10==0, sq=(k/10)&1.
        for (int k = 1; k <= 21; k++)
            add(4'b0001, 0, 0, 0, 0, (k % 10 == 0) ? 4'b0001 : 4'b0000,
                ((k / 10) % 2 == 1) ? 4'b0001 : 4'b0000, 4'b0000);
        // Edges 22..23 (cnt 1->3), edge 24 write 4 while cnt==3.
        for (int k = 0; k < 2; k++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 0, 1, 0, 32'd4, 4'b0000, 4'b0000, 4'b0001);
        for (int k = 0; k < 5; k++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001);
        // Edge 30: old period of 10 completes, reload, pend drops.
        add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
        for (int k = 0; k < 3; k++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
        add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
        // Edges 39..41, then edge 42 is terminal count (cnt==3) with a write of 6.
        for (int k = 0; k < 3; k++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
        add(4'b0001, 0, 1, 0, 32'd6, 4'b0001, 4'b0000, 4'b0000);
        // Zero write ignored; sel=3 write pends on the 4-ch part only (ch3 idle, applied next edge).
        add(4'b0001, 0, 1, 0, 32'd0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 0, 1, 3, 32'd7, 4'b0000, 4'b0000, 4'b1000);
        for (int k = 0; k < 3; k++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
        for (int k = 0; k < 5; k++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
        add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);

        // ---- reset state ----
        #12;
        chk("reset_tick", {28'd0, tick}, 32'd0);
        chk("reset_sq",   {28'd0, sq},   32'd0);
        chk("reset_pend", {28'd0, pend}, 32'd0);
        chk("reset_pend3", {29'd0, pend3}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].clr, vq[i].wr, vq[i].sel, vq[i].val);
            step();
            chk($sformatf("vec%0d_tick", i), {28'd0, tick}, {28'd0, vq[i].exp_tick});
            chk($sformatf("vec%0d_sq", i),   {28'd0, sq},   {28'd0, vq[i].exp_sq});
            chk($sformatf("vec%0d_pend", i), {28'd0, pend}, {28'd0, vq[i].exp_pend});
            chk($sformatf("vec%0d_pend3", i), {29'd0, pend3}, {29'd0, vq[i].exp_pend[2:0]});
            chk($sformatf("vec%0d_tick3", i), {29'd0, tick3}, {29'd0, vq[i].exp_tick[2:0]});
        end

        // ---- degenerate divisor on idle ch1 ----
        drive(4'b0001, 0, 1, 2'd1, 32'd1);
        step();
        chk("div1_pend_set", {31'd0, pend[1]}, 32'd1);
        drive(4'b0001, 0, 0, 2'd0, 32'd0);
        step();
        chk("div1_pend_clr", {31'd0, pend[1]}, 32'd0);
        chk("div1_idle_tick", {31'd0, tick[1]}, 32'd0);
        drive(4'b0011, 0, 0, 2'd0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("div1_tick_%0d", k), {31'd0, tick[1]}, 32'd1);
            chk($sformatf("div1_sq_%0d", k), {31'd0, sq[1]}, (k % 2 == 1) ? 32'd1 : 32'd0);
        end

        // ---- phase alignment with clr ----
        drive(4'b0000, 0, 1, 2'd0, 32'd8); step();
        drive(4'b0000, 0, 1, 2'd2, 32'd8); step();
        drive(4'b0000, 0, 1, 2'd1, 32'd9); step();
        drive(4'b0000, 0, 0, 2'd0, 32'd0); step();
        chk("align_pend_applied", {28'd0, pend}, 32'd0);
        drive(4'b0001, 0, 0, 2'd0, 32'd0);
        for (int k = 0; k < 3; k++) step();
        drive(4'b0101, 0, 0, 2'd0, 32'd0);
        for (int k = 0; k < 5; k++) step();
        drive(4'b0101, 1, 0, 2'd0, 32'd0);
        step();
        chk("clr_tick", {28'd0, tick & 4'b0101}, 32'd0);
        chk("clr_sq",   {28'd0, sq & 4'b0101},   32'd0);
        drive(4'b0101, 0, 0, 2'd0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("align_tick_%0d", k), {28'd0, tick & 4'b0101},
                (k == 8) ? 32'd5 : 32'd0);
        end
        chk("align_sq", {28'd0, sq & 4'b0101}, 32'd5);

        // ---- async reset mid-operation with a pending divisor ----
        drive(4'b0011, 0, 1, 2'd1, 32'd3);
        step();
        drive(4'b0011, 0, 0, 2'd0, 32'd0);
        step();
        chk("pre_rst_pend1", {31'd0, pend[1]}, 32'd1);
        chk("pre_rst_sq0",   {31'd0, sq[0]},   32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tick", {28'd0, tick}, 32'd0);
        chk("async_rst_sq",   {28'd0, sq},   32'd0);
        chk("async_rst_pend", {28'd0, pend}, 32'd0);
        #2 reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("post_rst_tick1_%0d", k), {31'd0, tick[1]}, (k == 10) ? 32'd1 : 32'd0);
        end
        chk("post_rst_pend", {28'd0, pend}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
